// File: rtl/jtag_axi_pkg.sv
// Shared JTAG-to-AXI definitions: TAP controller state encoding, instruction
// codes and the data-register selection used by the TAP shift register block.
package jtag_axi_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_ctrl_fsm_t;

  localparam logic [3:0] IR_IDCODE = 4'h1;
  localparam logic [3:0] IR_USER   = 4'h2;
  localparam logic [3:0] IR_BYPASS = 4'hF;

  localparam int IDCODE_WIDTH = 32;

  typedef enum logic [1:0] {
    DR_SEL_BYPASS,
    DR_SEL_IDCODE,
    DR_SEL_USER
  } dr_sel_t;

endpackage

// File: rtl/jtag_axi_shift_reg.sv
// Generic TAP shift register: parallel capture, right shift with tdi entering
// at the MSB, bit 0 presented as the serial output.
module jtag_axi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             tck,
  input  logic             trstn,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             lsb
);

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      q <= '0;
    end else if (capture) begin
      q <= load_value;
    end else if (shift) begin
      q <= {tdi, q[WIDTH-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/jtag_axi_tap_shift_regs.sv
// TAP register file: instruction register, BYPASS/IDCODE/USER data registers
// and the TDO mux, all driven by the TAP controller state on rising tck.
module jtag_axi_tap_shift_regs
  import jtag_axi_pkg::*;
#(
  parameter int                      IR_WIDTH   = 4,
  parameter int                      DR_WIDTH   = 64,
  parameter logic [IDCODE_WIDTH-1:0] IDCODE_VAL = 32'h1BEEF001
) (
  input  logic                tck,
  input  logic                trstn,
  input  tap_ctrl_fsm_t       tap_state,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic                dr_capture_strobe,
  input  logic [DR_WIDTH-1:0] dr_capture_data,
  output logic [DR_WIDTH-1:0] dr_update_data,
  output logic                dr_update_valid
);

  localparam logic [IR_WIDTH-1:0] IR_CODE_IDCODE = IR_WIDTH'(IR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CODE_USER   = IR_WIDTH'(IR_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(2'b01);

  dr_sel_t                   dr_sel;
  logic [IR_WIDTH-1:0]       ir_q;
  logic                      ir_lsb;
  logic [IDCODE_WIDTH-1:0]   unused_idcode_q;
  logic                      idcode_lsb;
  logic [DR_WIDTH-1:0]       user_q;
  logic                      user_lsb;
  logic                      bypass;

  logic capture_dr;
  logic shift_dr;

  // ir_value only moves at UPDATE_IR or TLR, so this selection is stable for a whole DR scan
  always_comb begin
    dr_sel = DR_SEL_BYPASS;
    if (ir_value == IR_CODE_IDCODE) begin
      dr_sel = DR_SEL_IDCODE;
    end else if (ir_value == IR_CODE_USER) begin
      dr_sel = DR_SEL_USER;
    end
  end

  assign capture_dr        = (tap_state == CAPTURE_DR);
  assign shift_dr          = (tap_state == SHIFT_DR);
  assign dr_capture_strobe = capture_dr && (dr_sel == DR_SEL_USER);

  jtag_axi_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_shift (
    .tck        (tck),
    .trstn      (trstn),
    .capture    (tap_state == CAPTURE_IR),
    .shift      (tap_state == SHIFT_IR),
    .tdi        (tdi),
    .load_value (IR_CAPTURE_VAL),
    .q          (ir_q),
    .lsb        (ir_lsb)
  );

  jtag_axi_shift_reg #(.WIDTH(IDCODE_WIDTH)) u_idcode_shift (
    .tck        (tck),
    .trstn      (trstn),
    .capture    (capture_dr && (dr_sel == DR_SEL_IDCODE)),
    .shift      (shift_dr && (dr_sel == DR_SEL_IDCODE)),
    .tdi        (tdi),
    .load_value (IDCODE_VAL),
    .q          (unused_idcode_q),
    .lsb        (idcode_lsb)
  );

  jtag_axi_shift_reg #(.WIDTH(DR_WIDTH)) u_user_shift (
    .tck        (tck),
    .trstn      (trstn),
    .capture    (capture_dr && (dr_sel == DR_SEL_USER)),
    .shift      (shift_dr && (dr_sel == DR_SEL_USER)),
    .tdi        (tdi),
    .load_value (dr_capture_data),
    .q          (user_q),
    .lsb        (user_lsb)
  );

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      bypass <= 1'b0;
    end else if (dr_sel == DR_SEL_BYPASS) begin
      if (capture_dr) begin
        bypass <= 1'b0;
      end else if (shift_dr) begin
        bypass <= tdi;
      end
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      ir_value <= IR_CODE_IDCODE;
    end else if (tap_state == TEST_LOGIC_RESET) begin
      ir_value <= IR_CODE_IDCODE;
    end else if (tap_state == UPDATE_IR) begin
      ir_value <= ir_q;
    end
  end

  // valid defaults low every edge, giving a single-cycle pulse per USER update
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      dr_update_data  <= '0;
      dr_update_valid <= 1'b0;
    end else begin
      dr_update_valid <= 1'b0;
      if ((tap_state == UPDATE_DR) && (dr_sel == DR_SEL_USER)) begin
        dr_update_data  <= user_q;
        dr_update_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    case (tap_state)
      SHIFT_IR: begin
        tdo    = ir_lsb;
        tdo_en = 1'b1;
      end
      SHIFT_DR: begin
        tdo_en = 1'b1;
        case (dr_sel)
          DR_SEL_IDCODE: tdo = idcode_lsb;
          DR_SEL_USER:   tdo = user_lsb;
          default:       tdo = bypass;
        endcase
      end
      default: begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jtag_axi_tap_shift_regs.sv
// Self-checking bench for the TAP register file: scans are modelled as
// transactions (captured value followed by shifted-in bits as one bit stream).
module tb_jtag_axi_tap_shift_regs;
  import jtag_axi_pkg::*;

  localparam int          IRW = 4;
  localparam int          DRW = 64;
  localparam logic [31:0] IDC = 32'h1BEEF001;

  logic            tck;
  logic            trstn;
  tap_ctrl_fsm_t   tap_state;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic [IRW-1:0]  ir_value;
  logic            dr_capture_strobe;
  logic [DRW-1:0]  dr_capture_data;
  logic [DRW-1:0]  dr_update_data;
  logic            dr_update_valid;

  jtag_axi_tap_shift_regs #(
    .IR_WIDTH   (IRW),
    .DR_WIDTH   (DRW),
    .IDCODE_VAL (IDC)
  ) dut (
    .tck               (tck),
    .trstn             (trstn),
    .tap_state         (tap_state),
    .tdi               (tdi),
    .tdo               (tdo),
    .tdo_en            (tdo_en),
    .ir_value          (ir_value),
    .dr_capture_strobe (dr_capture_strobe),
    .dr_capture_data   (dr_capture_data),
    .dr_update_data    (dr_update_data),
    .dr_update_valid   (dr_update_valid)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int n_checks = 0;
  int n_fail   = 0;

  // every cycle the update valid is seen high, and the data it carried
  int          hi_cnt = 0;
  logic [63:0] upd_q[$];
  always @(negedge tck) begin
    if (dr_update_valid === 1'b1) begin
      hi_cnt++;
      upd_q.push_back(dr_update_data);
    end
  end

  // reference model state
  logic [3:0]  m_ir;
  logic [63:0] m_upd;

  function automatic int reg_len(input logic [3:0] ir);
    if (ir == IR_IDCODE) return 32;
    if (ir == IR_USER)   return 64;
    return 1;
  endfunction

  function automatic logic [63:0] cap_val(input logic [3:0] ir, input logic [63:0] cdata);
    if (ir == IR_IDCODE) return {32'b0, IDC};
    if (ir == IR_USER)   return cdata;
    return 64'b0;
  endfunction

  // what a length-L register emits: its captured contents, then the bits fed in
  function automatic logic [127:0] scan_stream(input int len, input logic [63:0] c,
                                               input logic [63:0] t);
    logic [63:0] m;
    m = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
    return ({64'b0, t} << len) | {64'b0, c & m};
  endfunction

  task automatic tick(input tap_ctrl_fsm_t s, input logic b, output logic t);
    @(negedge tck);
    tap_state = s;
    tdi       = b;
    #1;
    t = tdo;
  endtask

  task automatic idle(input int n);
    logic b;
    repeat (n) tick(RUN_TEST_IDLE, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] out, output logic en_all);
    logic b;
    out    = '0;
    en_all = 1'b1;
    tick(SELECT_DR_SCAN, 1'b0, b);
    tick(SELECT_IR_SCAN, 1'b0, b);
    tick(CAPTURE_IR, 1'b0, b);
    for (int i = 0; i < IRW; i++) begin
      tick(SHIFT_IR, v[i], b);
      out[i] = b;
      en_all = en_all & tdo_en;
    end
    tick(EXIT1_IR, 1'b0, b);
    tick(UPDATE_IR, 1'b0, b);
    tick(RUN_TEST_IDLE, 1'b0, b);
  endtask

  // ends while tap_state is UPDATE_DR; caller picks the next state
  task automatic scan_dr(input logic [63:0] t_bits, input int n, input int pause_at,
                         output logic [63:0] out, output logic strobe);
    logic b;
    out = '0;
    tick(SELECT_DR_SCAN, 1'b0, b);
    tick(CAPTURE_DR, 1'b0, b);
    strobe = dr_capture_strobe;
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        tick(EXIT1_DR, 1'b0, b);
        repeat (5) tick(PAUSE_DR, 1'b0, b);
        tick(EXIT2_DR, 1'b0, b);
      end
      tick(SHIFT_DR, t_bits[i], b);
      out[i] = b;
    end
    tick(EXIT1_DR, 1'b0, b);
    tick(UPDATE_DR, 1'b0, b);
  endtask

  task automatic test_reset;
    trstn           = 1'b0;
    tap_state       = TEST_LOGIC_RESET;
    tdi             = 1'b0;
    dr_capture_data = '0;
    repeat (3) @(negedge tck);
    #1;
    n_checks++; if (ir_value !== IR_IDCODE) begin n_fail++; $display("FAIL reset_ir: got %h expected %h", ir_value, IR_IDCODE); end
    n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    n_checks++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_en: got %b expected 0", tdo_en); end
    n_checks++; if (dr_update_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dr_update_valid); end
    n_checks++; if (dr_update_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", dr_update_data); end
    trstn = 1'b1;
    m_ir  = IR_IDCODE;
    m_upd = '0;
  endtask

  task automatic test_idcode;
    logic        b, strobe;
    logic [63:0] t, out;
    logic [127:0] exp_s;
    int h0;
    tick(TEST_LOGIC_RESET, 1'b0, b);
    tick(RUN_TEST_IDLE, 1'b0, b);
    t  = {$urandom, $urandom};
    h0 = hi_cnt;
    scan_dr(t, 32, -1, out, strobe);
    idle(3);
    exp_s = scan_stream(reg_len(m_ir), cap_val(m_ir, dr_capture_data), t);
    n_checks++; if (out[31:0] !== IDC || out[31:0] !== exp_s[31:0]) begin n_fail++; $display("FAIL idcode_tdo: got %h expected %h", out[31:0], IDC); end
    n_checks++; if (ir_value !== m_ir) begin n_fail++; $display("FAIL idcode_ir: got %h expected %h", ir_value, m_ir); end
    n_checks++; if (strobe !== 1'b0) begin n_fail++; $display("FAIL idcode_strobe: got %b expected 0", strobe); end
    n_checks++; if (hi_cnt !== h0) begin n_fail++; $display("FAIL idcode_pulse: got %0d expected %0d", hi_cnt - h0, 0); end
  endtask

  task automatic test_ir_scan;
    logic [3:0] out;
    logic       en;
    scan_ir(IR_USER, out, en);
    m_ir = IR_USER;
    n_checks++; if (out !== 4'b0001) begin n_fail++; $display("FAIL ir_capture_tdo: got %b expected 0001", out); end
    n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL ir_tdo_en: got %b expected 1", en); end
    n_checks++; if (ir_value !== m_ir) begin n_fail++; $display("FAIL ir_update: got %h expected %h", ir_value, m_ir); end
  endtask

  task automatic test_user;
    logic         strobe;
    logic [63:0]  c, t, out, exp_out, last;
    logic [127:0] exp_s;
    int n, h0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        c = 64'hDEADBEEF_CAFEF00D;
        t = 64'h01234567_89ABCDEF;
        n = 64;
      end else begin
        c = {$urandom, $urandom};
        t = {$urandom, $urandom};
        n = $urandom_range(1, 64);
      end
      dr_capture_data = c;
      h0 = hi_cnt;
      scan_dr(t, n, -1, out, strobe);
      idle(3);
      exp_s   = scan_stream(reg_len(m_ir), cap_val(m_ir, c), t);
      exp_out = '0;
      for (int i = 0; i < n; i++) exp_out[i] = exp_s[i];
      m_upd = exp_s[n +: 64];
      last  = (upd_q.size() > 0) ? upd_q[$] : 64'hx;
      n_checks++; if (out !== exp_out) begin n_fail++; $display("FAIL user_tdo[%0d]: got %h expected %h", k, out, exp_out); end
      n_checks++; if (strobe !== 1'b1) begin n_fail++; $display("FAIL user_strobe[%0d]: got %b expected 1", k, strobe); end
      n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL user_update[%0d]: got %h expected %h", k, dr_update_data, m_upd); end
      n_checks++; if (hi_cnt - h0 !== 1) begin n_fail++; $display("FAIL user_pulse[%0d]: got %0d expected 1", k, hi_cnt - h0); end
      n_checks++; if (last !== m_upd) begin n_fail++; $display("FAIL user_pulse_data[%0d]: got %h expected %h", k, last, m_upd); end
    end
  endtask

  task automatic test_bypass;
    logic [3:0]   codes[4];
    logic [3:0]   o4;
    logic         en, strobe;
    logic [63:0]  t, out, exp_out;
    logic [127:0] exp_s;
    int n, h0;
    codes[0] = 4'h7;
    codes[1] = IR_BYPASS;
    codes[2] = 4'h0;
    do codes[3] = 4'($urandom_range(0, 15)); while (codes[3] == IR_IDCODE || codes[3] == IR_USER);
    for (int k = 0; k < 4; k++) begin
      scan_ir(codes[k], o4, en);
      m_ir = codes[k];
      if (k == 0) begin
        t = 64'b101;
        n = 3;
      end else begin
        t = {$urandom, $urandom};
        n = $urandom_range(2, 64);
      end
      dr_capture_data = {$urandom, $urandom};
      h0 = hi_cnt;
      scan_dr(t, n, -1, out, strobe);
      idle(3);
      exp_s   = scan_stream(reg_len(m_ir), cap_val(m_ir, dr_capture_data), t);
      exp_out = '0;
      for (int i = 0; i < n; i++) exp_out[i] = exp_s[i];
      n_checks++; if (out !== exp_out) begin n_fail++; $display("FAIL bypass_tdo[%h]: got %h expected %h", codes[k], out, exp_out); end
      n_checks++; if (hi_cnt !== h0 || strobe !== 1'b0) begin n_fail++; $display("FAIL bypass_no_pulse[%h]: got %0d pulses strobe %b expected 0", codes[k], hi_cnt - h0, strobe); end
      n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL bypass_data_held[%h]: got %h expected %h", codes[k], dr_update_data, m_upd); end
    end
  endtask

  task automatic test_tlr;
    logic [3:0] o4;
    logic       en, b;
    scan_ir(IR_USER, o4, en);
    tick(SELECT_DR_SCAN, 1'b0, b);
    tick(SELECT_IR_SCAN, 1'b0, b);
    tick(TEST_LOGIC_RESET, 1'b0, b);
    tick(RUN_TEST_IDLE, 1'b0, b);
    m_ir = IR_IDCODE;
    n_checks++; if (ir_value !== m_ir) begin n_fail++; $display("FAIL tlr_ir: got %h expected %h", ir_value, m_ir); end
    n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL tlr_data_held: got %h expected %h", dr_update_data, m_upd); end
  endtask

  task automatic test_pause;
    logic [3:0]  o4;
    logic        en, strobe;
    logic [63:0] c, t, out;
    int p, h0;
    scan_ir(IR_USER, o4, en);
    m_ir = IR_USER;
    c = {$urandom, $urandom};
    t = {$urandom, $urandom};
    p = $urandom_range(1, 62);
    dr_capture_data = c;
    h0 = hi_cnt;
    scan_dr(t, 64, p, out, strobe);
    idle(3);
    m_upd = t;
    n_checks++; if (out !== c) begin n_fail++; $display("FAIL pause_tdo: got %h expected %h", out, c); end
    n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL pause_update: got %h expected %h", dr_update_data, m_upd); end
    n_checks++; if (hi_cnt - h0 !== 1) begin n_fail++; $display("FAIL pause_pulse: got %0d expected 1", hi_cnt - h0); end
  endtask

  task automatic test_back_to_back;
    logic        strobe;
    logic [63:0] c1, t1, c2, t2, o1, o2;
    int h0, q0;
    c1 = {$urandom, $urandom};
    t1 = {$urandom, $urandom};
    c2 = {$urandom, $urandom};
    t2 = {$urandom, $urandom};
    dr_capture_data = c1;
    h0 = hi_cnt;
    q0 = upd_q.size();
    scan_dr(t1, 64, -1, o1, strobe);
    dr_capture_data = c2;
    scan_dr(t2, 64, -1, o2, strobe);
    idle(3);
    m_upd = t2;
    n_checks++; if (o1 !== c1 || o2 !== c2) begin n_fail++; $display("FAIL b2b_tdo: got %h/%h expected %h/%h", o1, o2, c1, c2); end
    n_checks++; if (hi_cnt - h0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", hi_cnt - h0); end
    if (upd_q.size() >= q0 + 2) begin
      n_checks++; if (upd_q[q0] !== t1) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", upd_q[q0], t1); end
      n_checks++; if (upd_q[q0+1] !== t2) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", upd_q[q0+1], t2); end
    end else begin
      n_checks++; n_fail++; $display("FAIL b2b_queue: got %0d entries expected %0d", upd_q.size() - q0, 2);
    end
    n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL b2b_final: got %h expected %h", dr_update_data, m_upd); end
  endtask

  task automatic test_trstn_mid;
    logic b;
    int h0;
    dr_capture_data = {$urandom, $urandom};
    tick(SELECT_DR_SCAN, 1'b0, b);
    tick(CAPTURE_DR, 1'b0, b);
    repeat (20) tick(SHIFT_DR, 1'($urandom), b);
    h0 = hi_cnt;
    #2;
    trstn = 1'b0;
    #1;
    m_ir  = IR_IDCODE;
    m_upd = '0;
    n_checks++; if (ir_value !== m_ir) begin n_fail++; $display("FAIL trst_ir: got %h expected %h", ir_value, m_ir); end
    n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL trst_data: got %h expected %h", dr_update_data, m_upd); end
    tap_state = TEST_LOGIC_RESET;
    repeat (2) @(negedge tck);
    trstn = 1'b1;
    tick(TEST_LOGIC_RESET, 1'b0, b);
    idle(4);
    n_checks++; if (hi_cnt !== h0) begin n_fail++; $display("FAIL trst_no_pulse: got %0d expected 0", hi_cnt - h0); end
    n_checks++; if (dr_update_data !== m_upd) begin n_fail++; $display("FAIL trst_data_after: got %h expected %h", dr_update_data, m_upd); end
    n_checks++; if (ir_value !== m_ir) begin n_fail++; $display("FAIL trst_ir_after: got %h expected %h", ir_value, m_ir); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_scan();
    test_user();
    test_bypass();
    test_tlr();
    test_pause();
    test_back_to_back();
    test_trstn_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
